// File: rtl/router_nic_port.sv
// router_nic_port: router-side endpoint of the NIC link.
// Two single-packet virtual-channel buffers per direction (even/odd).
// The link side addresses VC p and the switch side addresses VC ~p, where p
// toggles every cycle. The two sides therefore never touch the same buffer in
// the same cycle.
// Optional feature: define ROUTER_NIC_PORT_STATS_EN to add the 16-bit
// rx_count / tx_count link-handshake counters.
module router_nic_port #(
  parameter int PACKET_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    polarity,
  input  logic                    in_si,
  output logic                    in_ri,
  input  logic [0:PACKET_WIDTH-1] in_di,
  output logic                    out_so,
  input  logic                    out_ro,
  output logic [0:PACKET_WIDTH-1] out_do,
  output logic                    sw_rx_valid,
  input  logic                    sw_rx_ready,
  output logic [0:PACKET_WIDTH-1] sw_rx_data,
  input  logic                    sw_tx_valid,
  output logic                    sw_tx_ready,
  input  logic [0:PACKET_WIDTH-1] sw_tx_data
`ifdef ROUTER_NIC_PORT_STATS_EN
  ,
  output logic [15:0]             rx_count,
  output logic [15:0]             tx_count
`endif
);

  logic                    p;
  logic [0:PACKET_WIDTH-1] ib [2];
  logic [1:0]              ib_full;
  logic [0:PACKET_WIDTH-1] eb [2];
  logic [1:0]              eb_full;

  logic link_vc;
  logic sw_vc;
  logic in_hs;
  logic rx_hs;
  logic tx_hs;
  logic out_hs;

  // VC selection and handshakes; all outputs depend on registers only.
  assign link_vc = p;
  assign sw_vc   = ~p;

  assign in_ri       = ~ib_full[link_vc];
  assign sw_rx_valid = ib_full[sw_vc];
  assign sw_rx_data  = ib[sw_vc];
  assign sw_tx_ready = ~eb_full[sw_vc];
  assign out_so      = eb_full[link_vc];
  assign out_do      = eb_full[link_vc] ? eb[link_vc] : '0;
  assign polarity    = p;

  assign in_hs  = in_si & ~ib_full[link_vc];
  assign rx_hs  = ib_full[sw_vc] & sw_rx_ready;
  assign tx_hs  = sw_tx_valid & ~eb_full[sw_vc];
  assign out_hs = eb_full[link_vc] & out_ro;

  // Polarity toggle plus fill/drain of both buffer pairs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p       <= 1'b0;
      // NOTE: the data buffers are reset too, so sw_rx_data reads zero out of
      // reset rather than whatever the flops power up with.
      ib[0]   <= '0;
      ib[1]   <= '0;
      eb[0]   <= '0;
      eb[1]   <= '0;
      ib_full <= '0;
      eb_full <= '0;
    end else begin
      p <= ~p;
      if (in_hs) begin
        ib[link_vc]      <= in_di;
        ib_full[link_vc] <= 1'b1;
      end
      if (rx_hs) begin
        ib_full[sw_vc] <= 1'b0;
      end
      if (tx_hs) begin
        eb[sw_vc]      <= sw_tx_data;
        eb_full[sw_vc] <= 1'b1;
      end
      if (out_hs) begin
        eb_full[link_vc] <= 1'b0;
      end
    end
  end

`ifdef ROUTER_NIC_PORT_STATS_EN
  // Link-handshake counters, wrapping at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_count <= 16'h0000;
      tx_count <= 16'h0000;
    end else begin
      if (in_hs) rx_count <= rx_count + 16'h0001;
      if (out_hs) tx_count <= tx_count + 16'h0001;
    end
  end
`endif

endmodule
